// File: rtl/counter_up_ctl.sv
// Controlled up-counter: counts 0..limit with a start/busy/done handshake,
// a one-cycle terminal-count pulse, and one-shot or wrap modes.
module counter_up_ctl #(
    parameter int dw        = 8,
    parameter int DEF_LIMIT = 7
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          start,
    input  logic          ena,
    input  logic          wrap,
    input  logic          use_def,
    input  logic [dw-1:0] limit,
    output logic [dw-1:0] result,
    output logic          busy,
    output logic          done,
    output logic          tc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [dw-1:0] result_q, result_d;
    logic [dw-1:0] lim_q, lim_d;
    logic          mode_q, mode_d;
    logic          tc_q, tc_d;
    logic [dw-1:0] start_lim;

    assign start_lim = (limit == '0 && use_def) ? dw'(DEF_LIMIT) : limit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= '0;
            lim_q    <= '0;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            lim_q    <= lim_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN:     if (ena && result_q == lim_q && !mode_q) state_d = DONE;
                DONE:    if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Next values for the registered datapath outputs; tc is a pulse by default.
    always_comb begin
        result_d = result_q;
        lim_d    = lim_q;
        mode_d   = mode_q;
        tc_d     = 1'b0;
        if (clear) begin
            result_d = '0;
            lim_d    = '0;
            mode_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (state_q == IDLE) result_d = '0;
                    if (start) begin
                        lim_d    = start_lim;
                        mode_d   = wrap;
                        result_d = '0;
                    end
                end
                RUN: begin
                    if (ena) begin
                        if (result_q != lim_q) begin
                            result_d = result_q + dw'(1);
                        end else begin
                            tc_d = 1'b1;
                            if (mode_q) result_d = '0;
                        end
                    end
                end
                default: result_d = '0;
            endcase
        end
    end

    assign result = result_q;
    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign tc     = tc_q;

endmodule

// File: tb/tb_counter_up_ctl.sv
// Directed bench for counter_up_ctl: expectations are queued as stimulus is
// driven and popped/compared one time unit after the following clock edge.
module tb_counter_up_ctl;

    logic       clk = 1'b0;
    logic       reset, clear, start, ena, wrap, use_def;
    logic [7:0] limit;
    logic [7:0] result;
    logic       busy, done, tc;

    typedef struct packed {
        logic [7:0] result;
        logic       busy;
        logic       done;
        logic       tc;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    counter_up_ctl #(.dw(8), .DEF_LIMIT(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .start   (start),
        .ena     (ena),
        .wrap    (wrap),
        .use_def (use_def),
        .limit   (limit),
        .result  (result),
        .busy    (busy),
        .done    (done),
        .tc      (tc)
    );

    always #5 clk = ~clk;

    task automatic expect_push(input logic [7:0] r, input logic b, input logic d, input logic t);
        exp_t e;
        e.result = r;
        e.busy   = b;
        e.done   = d;
        e.tc     = t;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        vectors++;
        assert (sb.size() > 0) else begin
            miscompares++;
            $error("FAIL %s: scoreboard empty (size %0d, required >0)", tag, sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            vectors++;
            assert (result === e.result) else begin
                miscompares++;
                $error("FAIL %s result: got %0d expected %0d", tag, result, e.result);
            end
            vectors++;
            assert (busy === e.busy) else begin
                miscompares++;
                $error("FAIL %s busy: got %b expected %b", tag, busy, e.busy);
            end
            vectors++;
            assert (done === e.done) else begin
                miscompares++;
                $error("FAIL %s done: got %b expected %b", tag, done, e.done);
            end
            vectors++;
            assert (tc === e.tc) else begin
                miscompares++;
                $error("FAIL %s tc: got %b expected %b", tag, tc, e.tc);
            end
        end
    endtask

    // Queue the expectation, let one edge pass, then compare.
    task automatic tick(input logic [7:0] r, input logic b, input logic d, input logic t,
                        input string tag);
        expect_push(r, b, d, t);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    task automatic begin_run(input logic [7:0] lim, input logic w, input logic ud);
        start   = 1'b1;
        limit   = lim;
        wrap    = w;
        use_def = ud;
        tick(8'd0, 1'b1, 1'b0, 1'b0, "start");
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; start = 1'b0; ena = 1'b0;
        wrap = 1'b0; use_def = 1'b0; limit = 8'd0;
        tick(8'd0, 1'b0, 1'b0, 1'b0, "reset");
        reset = 1'b0;
        tick(8'd0, 1'b0, 1'b0, 1'b0, "idle");

        // One-shot, limit 3; ena high in the start cycle must be ignored.
        ena = 1'b1;
        begin_run(8'd3, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) tick(8'(i), 1'b1, 1'b0, 1'b0, "os_cnt");
        tick(8'd3, 1'b0, 1'b1, 1'b1, "os_tc");
        tick(8'd3, 1'b0, 1'b1, 1'b0, "os_tc_drop");

        // Asynchronous reset while result = 4 in RUN.
        begin_run(8'd9, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) tick(8'(i), 1'b1, 1'b0, 1'b0, "pre_rst");
        #2 reset = 1'b1;
        expect_push(8'd0, 1'b0, 1'b0, 1'b0);
        #1 check("async_rst");
        #1 reset = 1'b0;
        tick(8'd0, 1'b0, 1'b0, 1'b0, "rst_idle");

        // Wrap, limit 2, ena pattern 1,0,1,1,1.
        begin_run(8'd2, 1'b1, 1'b0);
        ena = 1'b1; tick(8'd1, 1'b1, 1'b0, 1'b0, "wr_e1");
        ena = 1'b0; tick(8'd1, 1'b1, 1'b0, 1'b0, "wr_hold");
        ena = 1'b1; tick(8'd2, 1'b1, 1'b0, 1'b0, "wr_e2");
        tick(8'd0, 1'b1, 1'b0, 1'b1, "wr_roll");
        tick(8'd1, 1'b1, 1'b0, 1'b0, "wr_after");
        clear = 1'b1; tick(8'd0, 1'b0, 1'b0, 0, "wr_clear");
        clear = 1'b0;

        // Default limit substitution, then limit 0 one-shot from DONE.
        begin_run(8'd0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) tick(8'(i), 1'b1, 1'b0, 1'b0, "def_cnt");
        tick(8'd7, 1'b0, 1'b1, 1'b1, "def_done");
        begin_run(8'd0, 1'b0, 1'b0);
        tick(8'd0, 1'b0, 1'b1, 1'b1, "z_done");
        tick(8'd0, 1'b0, 1'b1, 1'b0, "z_hold");

        // Wrap with limit 0: back-to-back tc pulses.
        begin_run(8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(8'd0, 1'b1, 1'b0, 1'b1, "zw_tc");
        clear = 1'b1; tick(8'd0, 1'b0, 1'b0, 1'b0, "zw_clear");
        clear = 1'b0;

        // Start/limit/wrap changes during RUN have no effect.
        begin_run(8'd5, 1'b0, 1'b0);
        start = 1'b1; limit = 8'd9; wrap = 1'b1;
        for (int i = 1; i <= 5; i++) tick(8'(i), 1'b1, 1'b0, 1'b0, "ign_cnt");
        start = 1'b0;
        tick(8'd5, 1'b0, 1'b1, 1'b1, "ign_done");

        // Restart from DONE with limit 1.
        begin_run(8'd1, 1'b0, 1'b0);
        tick(8'd1, 1'b1, 1'b0, 1'b0, "rs_cnt");
        tick(8'd1, 1'b0, 1'b1, 1'b1, "rs_done");

        // clear beats start in DONE.
        clear = 1'b1; start = 1'b1; limit = 8'd4;
        tick(8'd0, 1'b0, 1'b0, 1'b0, "clr_vs_start");
        clear = 1'b0; start = 1'b0;
        tick(8'd0, 1'b0, 1'b0, 1'b0, "clr_idle");

        // Full-scale one-shot.
        begin_run(8'd255, 1'b0, 1'b0);
        for (int i = 1; i <= 255; i++) tick(8'(i), 1'b1, 1'b0, 1'b0, "fs_cnt");
        tick(8'd255, 1'b0, 1'b1, 1'b1, "fs_done");
        tick(8'd255, 1'b0, 1'b1, 1'b0, "fs_hold");

        vectors++;
        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
